pwm_capture: RTL
================

# pwm_capture

Input-capture companion to the PWM timer core: the timer core generates a PWM/interrupt waveform; this block receives an external PWM waveform and measures it. Each cycle it reports period and high time (duty) in `chosen_clk` cycles, raises a sticky interrupt on each capture or on counter overflow, and supports continuous and one-shot modes. It sits beside the timer core in the PWM timer subsystem, with its results and control bits mapped into the Wishbone register file.

## Interface
- `WIDTH`, 16: width of the measurement counter and capture registers.
- `FILTER_LEN`, 3: glitch-filter depth in cycles; used only when the filter macro is defined.

- `chosen_clk` in 1: single block clock.
- `rst` in 1: synchronous, active-high reset.
- `pwm_in` in 1: external PWM input, asynchronous to `chosen_clk`.
- `cap_en` in 1: capture enable; low forces IDLE.
- `cont` in 1: 1 = continuous capture, 0 = one-shot.
- `irq_clr` in 1: one-cycle pulse; clears `irq` and `ovf`.
- `period_cap` out WIDTH: last captured period (rise to rise).
- `duty_cap` out WIDTH: last captured high time (rise to fall).
- `cap_valid` out 1: one-cycle pulse when `period_cap`/`duty_cap` update.
- `ovf` out 1: sticky; counter saturated without an edge.
- `irq` out 1: sticky; set on capture or overflow.
- `busy` out 1: high in ARM, HIGH, LOW.

## Operation
- Input path: 2-flop synchronizer, optional filter, edge register producing one-cycle `rise`/`fall` pulses.
- FSM states: IDLE, ARM, HIGH, LOW, DONE.
  - IDLE: `cnt=0`. If `cap_en`, go to ARM.
  - ARM: wait for `rise`, then go to HIGH with `cnt<=1`. The first edge only arms; no capture is made.
  - HIGH: `cnt` increments each cycle. On `fall`, latch `duty_cap<=cnt` and go to LOW.
  - LOW: `cnt` increments. On `rise`, load `period_cap<=cnt`, pulse `cap_valid`, set `irq`, and `cnt<=1`. Then go to HIGH if `cont=1`, else DONE.
  - DONE: hold until `cap_en` goes low, then IDLE.
- A sample sequence of H high cycles and L low cycles gives `duty_cap=H` and `period_cap=H+L`.
- `duty_cap` is latched internally at `fall` but presented only together with `period_cap` at `cap_valid`, so the two outputs are always a consistent pair.
- Overflow: if `cnt` reaches all-ones in HIGH or LOW:
  - set `ovf` and `irq`;
  - no `cap_valid`;
  - go to ARM.
  - Covers 0 % and 100 % duty and a stopped input.
- `cnt` never wraps.
- `cap_en` low in any state → IDLE next cycle, measurement discarded, capture registers hold their values.
- `irq_clr` together with a set event in the same cycle: set wins.
- Minimum measurable input: H≥1, L≥1 (period ≥2). Shorter pulses are lost at the synchronizer by construction; behaviour is undefined.

## Timing
- Reset values:
  - `period_cap=0`, `duty_cap=0`
  - `cap_valid=0`, `ovf=0`, `irq=0`, `busy=0`
  - state IDLE, `cnt=0`.
- Edge latency: `rise`/`fall` is asserted 3 cycles after the first `chosen_clk` edge that samples the new `pwm_in` level (2 sync + 1 edge reg), plus FILTER_LEN cycles when the filter is built.
- Outputs are registered; they update in the cycle after the `rise` that closes the period, with `cap_valid` in that same cycle.
- `irq` goes high in the same cycle as `cap_valid`. A later `irq_clr` drops it on the following cycle.
- `rst` has priority over all inputs.

## Configuration
- `PWM_CAPTURE_FILTER_EN` defined:
  - filtered level changes only after FILTER_LEN consecutive identical synchronized samples;
  - pulses shorter than FILTER_LEN are ignored;
  - both edges are delayed equally, so measurements of clean signals are unchanged.
- `PWM_CAPTURE_FILTER_EN` undefined: the synchronizer output feeds edge detection directly; no filter logic.

## Structure
- Shared package `pwm_timer_pkg`:
  - FSM state encoding localparams (IDLE/ARM/HIGH/LOW/DONE);
  - `CNT_MAX` derived from WIDTH.
- One sub-module `pwm_edge_sync`: synchronizer + optional filter + `rise`/`fall` generation. The FSM, counter and capture registers stay in the top.

## Test plan
- Continuous, `pwm_in` 3 high / 5 low repeating, filter off → first edge arms only; then `cap_valid` every 8 cycles with `duty_cap=3`, `period_cap=8`; `irq` stays high until `irq_clr`.
- One-shot (`cont=0`), same waveform → exactly one `cap_valid` (3/8), state DONE, `busy=0`; further edges are ignored until `cap_en` toggles low/high.
- `pwm_in` held high after arming, WIDTH=8 → `ovf=1`, `irq=1` after 255 counted cycles, no `cap_valid`; `irq_clr` clears both.
- `irq_clr` pulse in the same cycle as `cap_valid` → `irq` remains 1.
- `cap_en` dropped while in LOW → IDLE next cycle, `period_cap`/`duty_cap` unchanged, no `cap_valid`; on re-enable, the first edge only arms again.
- Filter built, FILTER_LEN=3, a 1-cycle glitch inside a 10/10 waveform → glitch ignored; `duty_cap=10`, `period_cap=20`.

Source files
------------

// File: rtl/pwm_timer_pkg.sv
// Shared types and constants for the PWM timer subsystem.
// Holds the capture FSM state encoding and counter limits.
package pwm_timer_pkg;

    localparam int unsigned CAP_WIDTH_DEF = 16;
    localparam int unsigned FILTER_LEN_DEF = 3;

    // Saturation value of a default-width measurement counter.
    localparam logic [CAP_WIDTH_DEF-1:0] CNT_MAX = {CAP_WIDTH_DEF{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } cap_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes pwm_in, optionally deglitches it, and emits rise/fall pulses.
// Ports: chosen_clk, rst, pwm_in -> rise, fall. Filter: PWM_CAPTURE_FILTER_EN.
module pwm_edge_sync
    import pwm_timer_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic chosen_clk,
    input  logic rst,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_q;

    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);

    logic [FW-1:0] run_cnt;

    // Level follows the input only after FILTER_LEN consecutive
    // samples disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            level   <= 1'b0;
            run_cnt <= '0;
        end else if (sync_2 == level) begin
            run_cnt <= '0;
        end else if (run_cnt == FLAST) begin
            level   <= sync_2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end
`else
    assign level = sync_2;

    // FILTER_LEN only shapes the filtered build.
    if (FILTER_LEN == 0) begin : g_no_filter
    end
`endif

    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
            fall    <= ~level & level_q;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM input in chosen_clk cycles.
// Ports: pwm_in/cap_en/cont/irq_clr in; period_cap/duty_cap/cap_valid/ovf/irq/busy out.
// Optional input deglitch filter: define PWM_CAPTURE_FILTER_EN.
module pwm_capture
    import pwm_timer_pkg::*;
#(
    parameter int unsigned WIDTH      = CAP_WIDTH_DEF,
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic             chosen_clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             cap_en,
    input  logic             cont,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] period_cap,
    output logic [WIDTH-1:0] duty_cap,
    output logic             cap_valid,
    output logic             ovf,
    output logic             irq,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_TOP = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic rise;
    logic fall;

    cap_state_t state;
    cap_state_t state_d;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_lat;
    logic [WIDTH-1:0] duty_lat_d;
    logic [WIDTH-1:0] period_d;
    logic [WIDTH-1:0] duty_d;
    logic             cap_valid_d;
    logic             ovf_set;

    pwm_edge_sync #(
        .FILTER_LEN(FILTER_LEN)
    ) u_edge (
        .chosen_clk(chosen_clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .rise      (rise),
        .fall      (fall)
    );

    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            duty_lat   <= '0;
            period_cap <= '0;
            duty_cap   <= '0;
            cap_valid  <= 1'b0;
            ovf        <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            duty_lat   <= duty_lat_d;
            period_cap <= period_d;
            duty_cap   <= duty_d;
            cap_valid  <= cap_valid_d;
            // Set events win over a simultaneous clear.
            ovf        <= ovf_set | (ovf & ~irq_clr);
            irq        <= ovf_set | cap_valid_d | (irq & ~irq_clr);
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        duty_lat_d  = duty_lat;
        period_d    = period_cap;
        duty_d      = duty_cap;
        cap_valid_d = 1'b0;
        ovf_set     = 1'b0;

        if (!cap_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    cnt_d = '0;
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    // Saturation is checked first so cnt never wraps.
                    if (cnt == CNT_TOP) begin
                        ovf_set = 1'b1;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else if (fall) begin
                        duty_lat_d = cnt;
                        cnt_d      = cnt + 1'b1;
                        state_d    = LOW;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == CNT_TOP) begin
                        ovf_set = 1'b1;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else if (rise) begin
                        period_d    = cnt;
                        duty_d      = duty_lat;
                        cap_valid_d = 1'b1;
                        cnt_d       = CNT_ONE;
                        state_d     = cont ? HIGH : DONE;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ARM) || (state == HIGH) || (state == LOW);

endmodule
